// File: rtl/dsa_host_arbiter.sv
// dsa_host_arbiter: two-requester round-robin front end for the DSA host bus.
// Writes are issued at full rate. A read holds the bus until h_rvalid arrives
// or the watchdog expires. The response is then routed to the requester that
// issued the read.
module dsa_host_arbiter #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    RD_TIMEOUT   = 64,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r0_wr,
    input  logic                  r0_rd,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_wait,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic                  r0_rvalid,
    input  logic                  r1_wr,
    input  logic                  r1_rd,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_wait,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  r1_rvalid,
    output logic                  h_wr_en,
    output logic                  h_rd_en,
    output logic [ADDR_WIDTH-1:0] h_addr,
    output logic [DATA_WIDTH-1:0] h_wdata,
    input  logic [DATA_WIDTH-1:0] h_rdata,
    input  logic                  h_rvalid,
    output logic                  busy,
    output logic [1:0]            err,
    input  logic                  err_clr
);

    localparam int CW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            owner_reg, owner_next;
    logic            last_grant_reg, last_grant_next;

    logic            req0, req1;
    logic            accept, sel, sel_wr, sel_rd;
    logic            resp_fire, timeout, spurious;
    logic [DATA_WIDTH-1:0] resp_data;

    logic [DATA_WIDTH-1:0] rdata_reg  [2];
    logic                  rvalid_reg [2];

    assign req0 = r0_wr | r0_rd;
    assign req1 = r1_wr | r1_rd;

    // Arbitration, read tracking and watchdog; stall outputs derive from the grant.
    // Accepts are gated by rst_n so nothing is granted while reset is held.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        accept          = 1'b0;
        sel             = 1'b0;
        sel_wr          = 1'b0;
        sel_rd          = 1'b0;
        resp_fire       = 1'b0;
        resp_data       = h_rdata;
        timeout         = 1'b0;
        spurious        = 1'b0;
        case (state_reg)
            IDLE: begin
                spurious = h_rvalid;
                if (rst_n && (req0 || req1)) begin
                    accept          = 1'b1;
                    sel             = (req0 && req1) ? ~last_grant_reg : req1;
                    last_grant_next = sel;
                    // wr wins over rd when a requester raises both
                    sel_wr          = sel ? r1_wr : r0_wr;
                    sel_rd          = ~sel_wr & (sel ? r1_rd : r0_rd);
                    if (sel_rd) begin
                        state_next = RD_WAIT;
                        owner_next = sel;
                        cnt_next   = '0;
                    end
                end
            end
            RD_WAIT: begin
                if (h_rvalid) begin
                    resp_fire  = 1'b1;
                    state_next = IDLE;
                end else if (cnt_reg == CW'(RD_TIMEOUT - 1)) begin
                    resp_fire  = 1'b1;
                    resp_data  = TIMEOUT_DATA;
                    timeout    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        r0_wait = rst_n & req0 & ~(accept & ~sel);
        r1_wait = rst_n & req1 & ~(accept & sel);
    end

    // FSM, arbitration history, host command and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            h_wr_en        <= 1'b0;
            h_rd_en        <= 1'b0;
            h_addr         <= '0;
            h_wdata        <= '0;
            err            <= 2'b00;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            h_wr_en        <= accept & sel_wr;
            h_rd_en        <= accept & sel_rd;
            if (accept) begin
                h_addr  <= sel ? r1_addr  : r0_addr;
                h_wdata <= sel ? r1_wdata : r0_wdata;
            end
            err[0] <= timeout  | (err[0] & ~err_clr);
            err[1] <= spurious | (err[1] & ~err_clr);
        end
    end

    // Per-requester response registers; only the read owner ever sees a pulse.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_reg[gi]  <= '0;
                    rvalid_reg[gi] <= 1'b0;
                end else begin
                    rvalid_reg[gi] <= resp_fire && (owner_reg == 1'(gi));
                    if (resp_fire && (owner_reg == 1'(gi)))
                        rdata_reg[gi] <= resp_data;
                end
            end
        end
    endgenerate

    assign r0_rdata  = rdata_reg[0];
    assign r0_rvalid = rvalid_reg[0];
    assign r1_rdata  = rdata_reg[1];
    assign r1_rvalid = rvalid_reg[1];
    assign busy      = (state_reg == RD_WAIT);

endmodule

// File: tb/tb_dsa_host_arbiter.sv
// Testbench for dsa_host_arbiter. Inputs are driven at the falling edge and
// outputs are sampled 1 ns later. Queues hold the expected host commands and
// read responses.
module tb_dsa_host_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_wr = 0, r0_rd = 0, r1_wr = 0, r1_rd = 0;
    logic [15:0] r0_addr = '0, r1_addr = '0;
    logic [31:0] r0_wdata = '0, r1_wdata = '0;
    logic        r0_wait, r1_wait, r0_rvalid, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic        h_wr_en, h_rd_en;
    logic [15:0] h_addr;
    logic [31:0] h_wdata;
    logic [31:0] h_rdata = '0;
    logic        h_rvalid = 1'b0;
    logic        busy;
    logic [1:0]  err;
    logic        err_clr = 1'b0;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [31:0] rsp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    dsa_host_arbiter #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .RD_TIMEOUT(8), .TIMEOUT_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_wr(r0_wr), .r0_rd(r0_rd), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_wait(r0_wait), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
        .r1_wr(r1_wr), .r1_rd(r1_rd), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_wait(r1_wait), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
        .h_wr_en(h_wr_en), .h_rd_en(h_rd_en), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_rdata(h_rdata), .h_rvalid(h_rvalid),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++; if (h_wr_en !== 1'b0 || h_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got wr=%b rd=%b want 0 0", h_wr_en, h_rd_en); end
        n_checks++; if (busy !== 1'b0 || err !== 2'b00) begin n_fail++; $display("FAIL reset_status: got busy=%b err=%b want 0 00", busy, err); end
        n_checks++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0 || r0_rdata !== 32'h0 || h_addr !== 16'h0) begin n_fail++; $display("FAIL reset_outputs: got r0v=%b r1v=%b r0d=%h ha=%h want zeros", r0_rvalid, r1_rvalid, r0_rdata, h_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_single_write();
        @(negedge clk);
        r0_wr = 1'b1; r0_addr = 16'h0004; r0_wdata = 32'h0000_00A5;
        #1;
        n_checks++; if (r0_wait !== 1'b0) begin n_fail++; $display("FAIL single_wait: got %b want 0", r0_wait); end
        cmd_q.push_back('{16'h0004, 32'h0000_00A5});
        @(negedge clk);
        r0_wr = 1'b0;
        #1;
        n_checks++; if (h_wr_en !== 1'b1 || h_rd_en !== 1'b0) begin n_fail++; $display("FAIL single_strobe: got wr=%b rd=%b want 1 0", h_wr_en, h_rd_en); end
        if (cmd_q.size() > 0) begin
            cmd_t c = cmd_q.pop_front();
            n_checks++; if (h_addr !== c.addr || h_wdata !== c.data) begin n_fail++; $display("FAIL single_cmd: got %h/%h want %h/%h", h_addr, h_wdata, c.addr, c.data); end
        end
        @(negedge clk);
        #1;
        n_checks++; if (h_wr_en !== 1'b0) begin n_fail++; $display("FAIL single_oneshot: got h_wr_en=%b want 0", h_wr_en); end
        $display("single_write: addr=0004 data=000000a5");
    endtask

    task automatic test_contention();
        logic mdl_last;
        int   n0, n1, pulses, first, last;
        logic w;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mdl_last = 1'b1; n0 = 0; n1 = 0; pulses = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc > 0) @(negedge clk);
            r0_wr = (n0 < 4); r0_addr = 16'h0100 + 16'(n0); r0_wdata = 32'hA000_0000 + 32'(n0);
            r1_wr = (n1 < 4); r1_addr = 16'h0200 + 16'(n1); r1_wdata = 32'hB000_0000 + 32'(n1);
            #1;
            if (h_wr_en === 1'b1) begin
                pulses++;
                if (first < 0) first = cyc;
                last = cyc;
                if (cmd_q.size() > 0) begin
                    cmd_t c = cmd_q.pop_front();
                    n_checks++; if (h_addr !== c.addr || h_wdata !== c.data) begin n_fail++; $display("FAIL cont_cmd: got %h/%h want %h/%h", h_addr, h_wdata, c.addr, c.data); end
                    $display("contention: host write addr=%h data=%h", h_addr, h_wdata);
                end
            end
            if (r0_wr || r1_wr) begin
                w = (r0_wr && r1_wr) ? ~mdl_last : r1_wr;
                n_checks++; if (r0_wait !== (r0_wr && w) || r1_wait !== (r1_wr && !w)) begin n_fail++; $display("FAIL cont_wait: got w0=%b w1=%b want %b %b", r0_wait, r1_wait, r0_wr && w, r1_wr && !w); end
                if (w) begin cmd_q.push_back('{r1_addr, r1_wdata}); n1++; end
                else   begin cmd_q.push_back('{r0_addr, r0_wdata}); n0++; end
                mdl_last = w;
            end
        end
        r0_wr = 1'b0; r1_wr = 1'b0;
        n_checks++; if (pulses !== 8 || (last - first) !== 7) begin n_fail++; $display("FAIL cont_pulses: got %0d pulses span %0d want 8 span 7", pulses, last - first); end
        n_checks++; if (cmd_q.size() !== 0) begin n_fail++; $display("FAIL cont_drain: got %0d left want 0", cmd_q.size()); end
    endtask

    task automatic test_read();
        @(negedge clk);
        r1_rd = 1'b1; r1_addr = 16'h0010;
        #1;
        n_checks++; if (r1_wait !== 1'b0) begin n_fail++; $display("FAIL read_accept: got r1_wait=%b want 0", r1_wait); end
        @(negedge clk);
        r1_rd = 1'b0; r0_wr = 1'b1; r0_addr = 16'h0020; r0_wdata = 32'h0000_0077;
        #1;
        n_checks++; if (h_rd_en !== 1'b1 || h_wr_en !== 1'b0 || h_addr !== 16'h0010) begin n_fail++; $display("FAIL read_issue: got rd=%b wr=%b addr=%h want 1 0 0010", h_rd_en, h_wr_en, h_addr); end
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            if (k == 4) begin
                h_rvalid = 1'b1; h_rdata = 32'h1234_5678;
                rsp_q.push_back(32'h1234_5678);
            end
            #1;
            n_checks++; if (busy !== 1'b1 || r0_wait !== 1'b1 || h_rd_en !== 1'b0) begin n_fail++; $display("FAIL read_wait: got busy=%b r0_wait=%b rd=%b want 1 1 0", busy, r0_wait, h_rd_en); end
        end
        @(negedge clk);
        h_rvalid = 1'b0;
        #1;
        n_checks++; if (r1_rvalid !== 1'b1 || r0_rvalid !== 1'b0) begin n_fail++; $display("FAIL read_rvalid: got r1v=%b r0v=%b want 1 0", r1_rvalid, r0_rvalid); end
        if (rsp_q.size() > 0) begin
            logic [31:0] e = rsp_q.pop_front();
            n_checks++; if (r1_rdata !== e) begin n_fail++; $display("FAIL read_data: got %h want %h", r1_rdata, e); end
        end
        n_checks++; if (busy !== 1'b0 || r0_wait !== 1'b0) begin n_fail++; $display("FAIL read_release: got busy=%b r0_wait=%b want 0 0", busy, r0_wait); end
        @(negedge clk);
        r0_wr = 1'b0;
        #1;
        n_checks++; if (h_wr_en !== 1'b1 || h_addr !== 16'h0020 || h_wdata !== 32'h77) begin n_fail++; $display("FAIL read_pending_wr: got wr=%b addr=%h data=%h want 1 0020 00000077", h_wr_en, h_addr, h_wdata); end
        n_checks++; if (r1_rvalid !== 1'b0 || r1_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL read_hold: got r1v=%b r1d=%h want 0 12345678", r1_rvalid, r1_rdata); end
        $display("read: r1 addr=0010 data=%h", r1_rdata);
    endtask

    task automatic test_timeout();
        int hit;
        @(negedge clk);
        r0_rd = 1'b1; r0_addr = 16'h0030;
        rsp_q.push_back(32'hDEAD_BEEF);
        #1;
        n_checks++; if (r0_wait !== 1'b0) begin n_fail++; $display("FAIL to_accept: got r0_wait=%b want 0", r0_wait); end
        hit = -1;
        for (int k = 1; k <= 20 && hit < 0; k++) begin
            @(negedge clk);
            r0_rd = 1'b0;
            #1;
            if (r0_rvalid === 1'b1) hit = k;
            else if (err !== 2'b00) begin n_checks++; n_fail++; $display("FAIL to_early_err: got %b want 00 at wait %0d", err, k); end
        end
        n_checks++; if (hit !== 9) begin n_fail++; $display("FAIL to_latency: got rvalid at cycle %0d want 9", hit); end
        if (rsp_q.size() > 0) begin
            logic [31:0] e = rsp_q.pop_front();
            n_checks++; if (r0_rdata !== e) begin n_fail++; $display("FAIL to_data: got %h want %h", r0_rdata, e); end
        end
        n_checks++; if (err !== 2'b01 || r1_rvalid !== 1'b0) begin n_fail++; $display("FAIL to_err: got err=%b r1v=%b want 01 0", err, r1_rvalid); end
        @(negedge clk);
        h_rvalid = 1'b1; h_rdata = 32'h5555_5555;
        @(negedge clk);
        h_rvalid = 1'b0;
        #1;
        n_checks++; if (err !== 2'b11 || r0_rvalid !== 1'b0) begin n_fail++; $display("FAIL to_spurious: got err=%b r0v=%b want 11 0", err, r0_rvalid); end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL to_clear: got err=%b want 00", err); end
        $display("timeout: r0 data=%h at wait cycle %0d", r0_rdata, hit);
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        r1_rd = 1'b1; r1_addr = 16'h0040;
        @(negedge clk);
        r1_rd = 1'b0;
        h_rvalid = 1'b1; h_rdata = 32'hCAFE_0001;
        rsp_q.push_back(32'hCAFE_0001);
        #1;
        n_checks++; if (h_rd_en !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL same_issue: got rd=%b busy=%b want 1 1", h_rd_en, busy); end
        @(negedge clk);
        h_rvalid = 1'b0;
        #1;
        n_checks++; if (r1_rvalid !== 1'b1 || busy !== 1'b0 || err !== 2'b00) begin n_fail++; $display("FAIL same_resp: got r1v=%b busy=%b err=%b want 1 0 00", r1_rvalid, busy, err); end
        if (rsp_q.size() > 0) begin
            logic [31:0] e = rsp_q.pop_front();
            n_checks++; if (r1_rdata !== e) begin n_fail++; $display("FAIL same_data: got %h want %h", r1_rdata, e); end
        end
        $display("same_cycle: r1 data=%h", r1_rdata);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        r0_rd = 1'b1; r0_addr = 16'h0050;
        @(negedge clk);
        r0_rd = 1'b0;
        @(negedge clk);
        r0_wr = 1'b1; r1_wr = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || h_rd_en !== 1'b0 || h_wr_en !== 1'b0 || err !== 2'b00) begin n_fail++; $display("FAIL mid_reset_status: got busy=%b rd=%b wr=%b err=%b want 0 0 0 00", busy, h_rd_en, h_wr_en, err); end
        n_checks++; if (r0_wait !== 1'b0 || r1_wait !== 1'b0 || r1_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_reset_outputs: got w0=%b w1=%b r1d=%h want 0 0 0", r0_wait, r1_wait, r1_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (r0_wait !== 1'b0 || r1_wait !== 1'b1) begin n_fail++; $display("FAIL mid_first_tie: got w0=%b w1=%b want 0 1", r0_wait, r1_wait); end
        @(negedge clk);
        r0_wr = 1'b0; r1_wr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_no_rvalid: got r0v=%b r1v=%b want 0 0", r0_rvalid, r1_rvalid); end
            @(negedge clk);
        end
        $display("reset_mid_read: read abandoned, first tie to r0");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_read();
        test_timeout();
        test_same_cycle();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
